// File: rtl/alu_pkg.sv
// Shared definitions for multi_op_alu: opcode and state encodings, operand-count split.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_ACC = 3'd6,
    OP_CLR = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Opcodes 0..TWO_OP_MAX take a B operand; everything above skips the B cycle.
  localparam int unsigned TWO_OP_MAX = 5;

endpackage

// File: rtl/multi_op_alu_exec.sv
// Combinational execute datapath for multi_op_alu.
// Accumulator ports and ACC/CLR opcodes exist only when MULTI_OP_ALU_ACC_EN is defined.
module multi_op_alu_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   a,
  input  logic [DATA_WIDTH-1:0]   b,
`ifdef MULTI_OP_ALU_ACC_EN
  input  logic [DATA_WIDTH-1:0]   acc,
  output logic [DATA_WIDTH-1:0]   acc_next,
`endif
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    overflow,
  output logic                    illegal
);

  localparam int MSB     = DATA_WIDTH - 1;
  localparam int SHIFT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic                  in_range;
  op_t                   op;

  assign sum      = a + b;
  assign diff     = a - b;
  assign in_range = (opcode <= OPCODE_WIDTH'(OP_CLR));
  assign op       = op_t'(opcode[2:0]);

`ifdef MULTI_OP_ALU_ACC_EN
  logic [DATA_WIDTH-1:0] acc_sum;
  assign acc_sum = acc + a;
`endif

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = !in_range;
`ifdef MULTI_OP_ALU_ACC_EN
    acc_next = acc;
`endif
    if (in_range) begin
      case (op)
        OP_ADD: begin
          result   = sum;
          overflow = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
        end
        OP_SUB: begin
          result   = diff;
          overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
        end
        OP_AND: result = a & b;
        OP_OR:  result = a | b;
        OP_XOR: result = a ^ b;
        OP_SHL: result = a << b[SHIFT_W-1:0];
`ifdef MULTI_OP_ALU_ACC_EN
        OP_ACC: begin
          result   = acc_sum;
          overflow = (acc[MSB] == a[MSB]) && (acc_sum[MSB] != acc[MSB]);
          acc_next = acc_sum;
        end
        OP_CLR: begin
          result   = '0;
          acc_next = '0;
        end
`else
        OP_ACC, OP_CLR: illegal = 1'b1;
`endif
      endcase
    end
  end

endmodule

// File: rtl/multi_op_alu.sv
// Multi-opcode ALU: operand-capture FSM, registered result/overflow/done, optional accumulator.
// Optional feature macro: MULTI_OP_ALU_ACC_EN (accumulator and opcodes ACC/CLR).
module multi_op_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int OPCODE_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    opcode_valid,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   data,
  output logic                    done,
  output logic                    overflow,
  output logic [DATA_WIDTH-1:0]   result,
  output logic                    busy
);

  state_t                  state;
  state_t                  state_next;
  logic [OPCODE_WIDTH-1:0] op_q;
  logic [DATA_WIDTH-1:0]   a_q;
  logic [DATA_WIDTH-1:0]   b_q;
  logic [DATA_WIDTH-1:0]   exec_result;
  logic                    exec_overflow;
  logic                    exec_illegal;

`ifdef MULTI_OP_ALU_ACC_EN
  logic [DATA_WIDTH-1:0] acc;
  logic [DATA_WIDTH-1:0] acc_next;
`endif

  multi_op_alu_exec #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OPCODE_WIDTH(OPCODE_WIDTH)
  ) u_exec (
    .opcode  (op_q),
    .a       (a_q),
    .b       (b_q),
`ifdef MULTI_OP_ALU_ACC_EN
    .acc     (acc),
    .acc_next(acc_next),
`endif
    .result  (exec_result),
    .overflow(exec_overflow),
    .illegal (exec_illegal)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (opcode_valid) begin
          state_next = (opcode <= OPCODE_WIDTH'(TWO_OP_MAX)) ? GET_B : EXEC;
        end
      end
      GET_B:   state_next = EXEC;
      EXEC:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
    end else begin
      state <= state_next;
      done  <= (state == EXEC);
      if (state == IDLE && opcode_valid) begin
        op_q <= opcode;
        a_q  <= data;
      end
      if (state == GET_B) begin
        b_q <= data;
      end
      // Illegal opcodes report a clean zero result regardless of what the datapath produced.
      if (state == EXEC) begin
        result   <= exec_illegal ? '0 : exec_result;
        overflow <= exec_illegal ? 1'b0 : exec_overflow;
      end
    end
  end

`ifdef MULTI_OP_ALU_ACC_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (state == EXEC && !exec_illegal) begin
      acc <= acc_next;
    end
  end
`endif

endmodule

// File: tb/tb_multi_op_alu.sv
// Self-checking bench for multi_op_alu: 8-bit table vectors, back-to-back starts,
// mid-operation reset, and a 16-bit/4-bit-opcode instance for illegal opcodes.
module tb_multi_op_alu;

`ifdef MULTI_OP_ALU_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        valid8, valid16;
  logic [2:0]  op8;
  logic [3:0]  op16;
  logic [7:0]  data8, result8;
  logic [15:0] data16, result16;
  logic        done8, ovf8, busy8;
  logic        done16, ovf16, busy16;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_op_alu #(.DATA_WIDTH(8), .OPCODE_WIDTH(3)) dut8 (
    .clk(clk), .reset_n(reset_n), .opcode_valid(valid8), .opcode(op8), .data(data8),
    .done(done8), .overflow(ovf8), .result(result8), .busy(busy8)
  );

  multi_op_alu #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .opcode_valid(valid16), .opcode(op16), .data(data16),
    .done(done16), .overflow(ovf16), .result(result16), .busy(busy16)
  );

  typedef struct {
    string       name;
    int          op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [7:0]  res;
    logic        ovf;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", name, got, exp);
    end
  endtask

  task automatic add_vec(input string name, input int op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] res, input logic ovf, input int lat);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Called #1 into an idle cycle T; returns result/overflow and done latency (0 = no done).
  task automatic run_op(input bit wide, input string name, input int op,
                        input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] res, output logic ovf, output int lat);
    res = '0;
    ovf = 1'b0;
    lat = 0;
    if (wide) begin
      op16 = op[3:0]; data16 = a; valid16 = 1'b1;
    end else begin
      op8 = op[2:0]; data8 = a[7:0]; valid8 = 1'b1;
    end
    @(posedge clk); #1;
    valid8 = 1'b0; valid16 = 1'b0;
    data8 = b[7:0]; data16 = b;
    check({name, "_busy_t1"}, wide ? busy16 : busy8, 1);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (wide ? done16 : done8) begin
        lat = k + 1;
        res = wide ? result16 : {8'h00, result8};
        ovf = wide ? ovf16 : ovf8;
        break;
      end
    end
    @(posedge clk); #1;
    check({name, "_done_drop"}, wide ? done16 : done8, 0);
    check({name, "_idle"}, wide ? busy16 : busy8, 0);
  endtask

  initial begin
    logic [15:0] res;
    logic        ovf;
    int          lat;
    int          n_done, first_k, last_k;

    add_vec("add_ovf",  0, 8'h7F, 8'h01, 8'h80, 1'b1, 3);
    add_vec("add_plain",0, 8'h10, 8'h20, 8'h30, 1'b0, 3);
    add_vec("add_negneg",0,8'h80, 8'h80, 8'h00, 1'b1, 3);
    add_vec("sub_ovf",  1, 8'h80, 8'h01, 8'h7F, 1'b1, 3);
    add_vec("sub_ovf2", 1, 8'h7F, 8'hFF, 8'h80, 1'b1, 3);
    add_vec("sub_plain",1, 8'h05, 8'h03, 8'h02, 1'b0, 3);
    add_vec("and",      2, 8'hF0, 8'h3C, 8'h30, 1'b0, 3);
    add_vec("or",       3, 8'hF0, 8'h0F, 8'hFF, 1'b0, 3);
    add_vec("xor",      4, 8'hFF, 8'h0F, 8'hF0, 1'b0, 3);
    add_vec("shl_trunc",5, 8'h81, 8'h0B, 8'h08, 1'b0, 3);
    add_vec("clr",      7, 8'h55, 8'h00, 8'h00, 1'b0, 2);
    add_vec("acc_5",    6, 8'h05, 8'h00, ACC_EN ? 8'h05 : 8'h00, 1'b0, 2);
    add_vec("acc_7e",   6, 8'h7E, 8'h00, ACC_EN ? 8'h83 : 8'h00, ACC_EN, 2);
    add_vec("acc_1",    6, 8'h01, 8'h00, ACC_EN ? 8'h84 : 8'h00, 1'b0, 2);

    reset_n = 1'b0;
    valid8 = 1'b0; valid16 = 1'b0;
    op8 = '0; op16 = '0; data8 = '0; data16 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", done8, 0);
    check("rst_busy", busy8, 0);
    check("rst_result", result8, 0);
    check("rst_ovf", ovf8, 0);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(1'b0, vecs[i].name, vecs[i].op, {8'h00, vecs[i].a}, {8'h00, vecs[i].b}, res, ovf, lat);
      check({vecs[i].name, "_result"}, res, {8'h00, vecs[i].res});
      check({vecs[i].name, "_ovf"}, ovf, vecs[i].ovf);
      check({vecs[i].name, "_latency"}, lat, vecs[i].lat);
    end

    // opcode_valid held high: starts land every 4 cycles, the rest are ignored.
    n_done = 0; first_k = 0; last_k = 0;
    valid8 = 1'b1; op8 = 3'd0; data8 = 8'h01;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done8) begin
        n_done++;
        if (first_k == 0) first_k = k;
        last_k = k;
        check("stream_result", result8, 8'h02);
      end
    end
    valid8 = 1'b0;
    check("stream_count", n_done, 5);
    check("stream_first", first_k, 3);
    check("stream_last", last_k, 19);
    check("stream_idle", busy8, 0);

    // Reset while in GET_B aborts without a done.
    valid8 = 1'b1; op8 = 3'd0; data8 = 8'h02;
    @(posedge clk); #1;
    valid8 = 1'b0; data8 = 8'h03;
    check("abort_busy", busy8, 1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("abort_done", done8, 0);
    check("abort_result", result8, 0);
    check("abort_ovf", ovf8, 0);
    check("abort_busy_clr", busy8, 0);
    reset_n = 1'b1;
    n_done = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done8) n_done++;
    end
    check("abort_no_done", n_done, 0);
    run_op(1'b0, "post_abort", 0, 16'h0002, 16'h0003, res, ovf, lat);
    check("post_abort_result", res, 16'h0005);
    check("post_abort_latency", lat, 3);

    // 16-bit instance: illegal opcode 9 leaves the accumulator untouched.
    run_op(1'b1, "w_acc", 6, 16'h0100, 16'h0000, res, ovf, lat);
    check("w_acc_result", res, ACC_EN ? 16'h0100 : 16'h0000);
    check("w_acc_latency", lat, 2);
    run_op(1'b1, "w_illegal", 9, 16'h1234, 16'h5678, res, ovf, lat);
    check("w_illegal_result", res, 16'h0000);
    check("w_illegal_ovf", ovf, 0);
    check("w_illegal_latency", lat, 2);
    run_op(1'b1, "w_acc2", 6, 16'h0001, 16'h0000, res, ovf, lat);
    check("w_acc2_result", res, ACC_EN ? 16'h0101 : 16'h0000);
    run_op(1'b1, "w_add", 0, 16'h7FFF, 16'h0001, res, ovf, lat);
    check("w_add_result", res, 16'h8000);
    check("w_add_ovf", ovf, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_op_alu.md
# multi_op_alu

Parametrised, multi-opcode successor to the team's serial ALU. It accepts an opcode plus one or two operands over a shared `data` bus, with the operands arriving on consecutive cycles. It computes the result in a registered execute stage and reports it with a one-cycle `done` pulse and a signed `overflow` flag. It sits between the stimulus driver and the checker in the ALU testbench, on the same free-running clock.

## Interface
- `DATA_WIDTH`, default 8: operand, result and accumulator width.
- `OPCODE_WIDTH`, default 3: opcode field width; must be ≥ 3.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `reset_n`, input, 1: reset, synchronous, active-low.
- `opcode_valid`, input, 1: start strobe; sampled only in IDLE.
- `opcode`, input, OPCODE_WIDTH: operation, sampled with `opcode_valid`.
- `data`, input, DATA_WIDTH: operand A in the start cycle; operand B in the following cycle.
- `done`, output, 1: one-cycle pulse; `result` and `overflow` are valid.
- `overflow`, output, 1: signed overflow of the completed operation.
- `result`, output, DATA_WIDTH: completed result; holds until the next `done`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SHL: A << B[$clog2(DATA_WIDTH)-1:0].
  - 6 ACC: acc ← acc+A; result = new acc.
  - 7 CLR: acc ← 0; result = 0.
  - Opcode values above 7 are illegal.
- Two-operand ops are 0–5. Single-operand ops are 6 and 7; their B cycle is skipped.
- States:
  - IDLE: on `opcode_valid`, capture opcode and A. Go to GET_B for ops 0–5, otherwise to EXEC.
  - GET_B: capture `data` as B, go to EXEC.
  - EXEC: register result, overflow and accumulator; assert `done`; go to DONE.
  - DONE: deassert `done`, go to IDLE.
- `opcode_valid` outside IDLE is ignored. It is neither queued nor an error.
- Arithmetic wraps modulo 2^DATA_WIDTH. Operands are two's complement for overflow purposes.
- Overflow rules:
  - ADD/ACC: operand signs equal and result sign differs.
  - SUB: operand signs differ and result sign differs from A.
  - All other ops: overflow = 0.
- SHL shift amount ≥ DATA_WIDTH cannot occur, because B is truncated to the shift field.
- Illegal opcode: `done` pulses with `result` = 0 and `overflow` = 0. The accumulator is unchanged.

## Timing
- Start cycle T has `opcode_valid` = 1.
- Two-operand ops:
  - B is sampled in T+1.
  - `done`, `result` and `overflow` are valid in T+3.
  - Next start is accepted in T+4 at the earliest.
- Single-operand ops: `done` in T+2; next start accepted at T+3.
- `busy` is 1 from T+1 through the DONE cycle inclusive.
- Reset (`reset_n` = 0 at a rising edge) sets:
  - state = IDLE, `done` = 0, `overflow` = 0, `result` = 0, `busy` = 0, acc = 0.
- Reset mid-operation aborts the operation, and no `done` is produced. Reset during the DONE cycle clears `done` at that edge.
- Reset has priority over `opcode_valid` in the same cycle.

## Configuration
- `MULTI_OP_ALU_ACC_EN` defined: accumulator register and opcodes 6/7 are implemented as above.
- `MULTI_OP_ALU_ACC_EN` undefined: no accumulator register exists, and opcodes 6/7 are treated as illegal. They still use the single-operand path: `done` at T+2 with `result` = 0 and `overflow` = 0.

## Structure
- The shared package `alu_pkg` holds:
  - opcode enum/localparams OP_ADD…OP_CLR;
  - state encoding IDLE/GET_B/EXEC/DONE;
  - a helper constant for the two-operand opcode range.
- Sub-module `multi_op_alu_exec` is purely combinational. Inputs: opcode, A, B, acc. Outputs: result, overflow, next acc, illegal flag.
- `multi_op_alu` holds the FSM and all registers.

## Test plan
All scenarios use DATA_WIDTH = 8 unless noted.
- ADD 0x7F+0x01 → `done` at T+3, result = 0x80, overflow = 1. Then ADD 0x10+0x20 → result = 0x30, overflow = 0.
- SUB 0x80−0x01 → result = 0x7F, overflow = 1. SHL 0x81 by B = 0x0B (amount 3) → result = 0x08, overflow = 0.
- ACC sequence:
  - CLR → `done` at T+2, result = 0.
  - ACC 0x05 → result 0x05; ACC 0x7E → result 0x83, overflow = 1.
  - Without the macro: the same stimulus gives result = 0, overflow = 0, `done` at T+2.
- `opcode_valid` held high continuously with ADD 1+1 → exactly one `done` every 4 cycles. Starts presented while `busy` is high are ignored.
- Assert reset in GET_B → no `done`; all outputs are 0 on the next cycle. A fresh ADD 2+3 afterwards → result = 5.
- DATA_WIDTH = 16, OPCODE_WIDTH = 4, opcode 9 → `done` at T+2, result = 0, overflow = 0, accumulator unchanged.
